// File: rtl/lsu_dmem_if.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction at a time, lane-aligned and extended loads.
// Store resp 2 cycles after accept, load resp 1 cycle after rvalid; busy_o stalls core; LSU_MISALIGN_TRAP_EN traps misaligned.
module lsu_dmem_if #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        req_ready_o,
   output logic        busy_o,
   output logic        resp_valid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state_q, state_d;
   logic [29:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [1:0]    off_q, off_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
   logic          mis_q, mis_d;
   logic          misaligned;
`endif

   logic [1:0]  req_off;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] ld_shift;
   logic [31:0] ld_ext;
   logic        timeout_hit;

   // Lane offset, enables and replicated data for the incoming request; misaligned low bits are masked
   always_comb begin
      req_off   = 2'b00;
      req_be    = 4'b1111;
      req_wdata = wdata_i;
      case (req_size_i)
         2'b00: begin
            req_off   = addr_i[1:0];
            req_be    = 4'b0001 << addr_i[1:0];
            req_wdata = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            req_off   = {addr_i[1], 1'b0};
            req_be    = 4'b0011 << {addr_i[1], 1'b0};
            req_wdata = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((req_size_i == 2'b01) && addr_i[0]) ||
                       (req_size_i[1] && (addr_i[1:0] != 2'b00));
`endif

   assign ld_shift = mem_rdata_i >> {off_q, 3'b000};

   always_comb begin
      ld_ext = ld_shift;
      case (size_q)
         2'b00:   ld_ext = uns_q ? {24'h0, ld_shift[7:0]}  : {{24{ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_ext = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TO_LAST);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_d   = mis_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               addr_d  = addr_i[31:2];
               we_d    = req_we_i;
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               off_d   = req_off;
               be_d    = req_be;
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
               mis_d   = misaligned;
               if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 1'b1;
            // Grant takes priority over a simultaneous timeout
            if (mem_gnt_i) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_rvalid_i) begin
               rdata_d = ld_ext;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   // Memory-side outputs are zero outside REQ so reset and idle look identical
   assign req_ready_o  = (state_q == S_IDLE);
   assign busy_o       = (state_q == S_REQ) || (state_q == S_WAIT);
   assign resp_valid_o = (state_q == S_DONE);
   assign rdata_o      = (state_q == S_DONE) ? rdata_q : 32'h0;
   assign err_o        = (state_q == S_DONE) && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_o   = (state_q == S_DONE) && mis_q;
`else
   assign misalign_o   = 1'b0;
`endif
   assign mem_req_o    = (state_q == S_REQ);
   assign mem_we_o     = mem_req_o && we_q;
   assign mem_be_o     = mem_req_o ? be_q : 4'h0;
   assign mem_addr_o   = mem_req_o ? {addr_q, 2'b00} : 32'h0;
   assign mem_wdata_o  = mem_req_o ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: vector table plus stall, timeout, reset and misalign sequences.
module tb_lsu_dmem_if;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] addr, wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   logic        req_ready, busy, resp_valid, err, misalign;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] rdata, mem_addr, mem_wdata;

   logic        req_ready_4, busy_4, resp_valid_4, err_4, misalign_4;
   logic        mem_req_4, mem_we_4;
   logic [3:0]  mem_be_4;
   logic [31:0] rdata_4, mem_addr_4, mem_wdata_4;

   int checks = 0;
   int errors = 0;

   lsu_dmem_if dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
      .req_unsigned_i(req_unsigned), .addr_i(addr), .wdata_i(wdata),
      .req_ready_o(req_ready), .busy_o(busy), .resp_valid_o(resp_valid),
      .rdata_o(rdata), .err_o(err), .misalign_o(misalign),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   lsu_dmem_if #(.TIMEOUT(4)) dut4 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
      .req_unsigned_i(req_unsigned), .addr_i(addr), .wdata_i(wdata),
      .req_ready_o(req_ready_4), .busy_o(busy_4), .resp_valid_o(resp_valid_4),
      .rdata_o(rdata_4), .err_o(err_4), .misalign_o(misalign_4),
      .mem_req_o(mem_req_4), .mem_we_o(mem_we_4), .mem_be_o(mem_be_4),
      .mem_addr_o(mem_addr_4), .mem_wdata_o(mem_wdata_4),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      int          wait_cyc;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      addr         = a;
      wdata        = wd;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ctrl"}, 32'({req_ready, busy, resp_valid, err, misalign, mem_req, mem_we, mem_be}),
          32'h400);
      chk({tag, "_rdata"}, rdata, 32'h0);
      chk({tag, "_maddr"}, mem_addr, 32'h0);
      chk({tag, "_mwdata"}, mem_wdata, 32'h0);
   endtask

   task automatic run_vec(input vec_t v);
      issue(v.we, v.size, v.uns, v.addr, v.wdata);
      tick();
      req_valid = 1'b0;
      addr      = 32'hFFFF_FFFF;
      wdata     = 32'h0;
      chk("vec_mem_req", 32'(mem_req), 32'h1);
      chk("vec_mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
      chk("vec_mem_be", 32'(mem_be), 32'(v.be));
      chk("vec_mem_wdata", mem_wdata, v.mwd);
      chk("vec_mem_we", 32'(mem_we), 32'(v.we));
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      if (!v.we) begin
         for (int k = 0; k < v.wait_cyc; k++) begin
            chk("vec_wait_busy", 32'({busy, mem_req, resp_valid}), 32'h4);
            tick();
         end
         mem_rvalid = 1'b1;
         mem_rdata  = v.mrd;
         tick();
         mem_rvalid = 1'b0;
         mem_rdata  = 32'h0;
      end
      chk("vec_resp", 32'({resp_valid, err, misalign}), 32'h4);
      chk("vec_rdata", rdata, v.rd);
      tick();
      chk("vec_idle", 32'({req_ready, resp_valid, busy}), 32'h4);
   endtask

   initial begin
      vec_t v;
      int   cyc;
      vecs[0] = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h1234_56A5, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
      vecs[1] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'hDEAD_BEEF, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      vecs[2] = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0};
      vecs[3] = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 1, 4'b1100, 32'h0, 32'hFFFF_8001};
      vecs[4] = '{1'b0, 2'd0, 1'b1, 32'h001, 32'h0, 32'h0000_F000, 0, 4'b0010, 32'h0, 32'h0000_00F0};
      vecs[5] = '{1'b0, 2'd0, 1'b0, 32'h003, 32'h0, 32'h8000_0000, 2, 4'b1000, 32'h0, 32'hFFFF_FF80};
      vecs[6] = '{1'b0, 2'd1, 1'b1, 32'h000, 32'h0, 32'h1234_ABCD, 0, 4'b0011, 32'h0, 32'h0000_ABCD};
      vecs[7] = '{1'b0, 2'd3, 1'b0, 32'h008, 32'h0, 32'h89AB_CDEF, 0, 4'b1111, 32'h0, 32'h89AB_CDEF};
      vecs[8] = '{1'b0, 2'd0, 1'b0, 32'h002, 32'h0, 32'h0012_7F00, 0, 4'b0100, 32'h0, 32'h0000_0012};

      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #1;
      chk_reset_state("reset");
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Stall: gnt low for 5 cycles, a new request and a stray rvalid pulsed meanwhile
      issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
      tick();
      for (int c = 1; c <= 5; c++) begin
         chk("stall_req", 32'({mem_req, req_ready, mem_we}), 32'h4);
         chk("stall_addr", mem_addr, 32'h300);
         req_valid  = (c == 2);
         req_we     = (c == 2);
         addr       = (c == 2) ? 32'h400 : 32'h300;
         mem_rvalid = (c == 2);
         mem_rdata  = (c == 2) ? 32'hDEAD_0000 : 32'h0;
         tick();
      end
      chk("stall_hold", 32'({mem_req, busy}), 32'h3);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("stall_wait", 32'({mem_req, busy, resp_valid}), 32'h2);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1122_3344;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk("stall_resp", 32'({resp_valid, err}), 32'h2);
      chk("stall_rdata", rdata, 32'h1122_3344);
      tick();
      chk("stall_no_second", 32'({req_ready, mem_req}), 32'h2);

      // Timeout: dut4 aborts after 4 REQ cycles, the default instance after 16
      issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
      tick();
      req_valid = 1'b0;
      cyc = 1;
      for (int c = 1; c <= 4; c++) begin
         chk("to4_req", 32'({mem_req_4, resp_valid_4}), 32'h2);
         tick();
         cyc++;
      end
      chk("to4_resp", 32'({resp_valid_4, err_4, mem_req_4}), 32'h6);
      chk("to4_rdata", rdata_4, 32'h0);
      tick();
      cyc++;
      chk("to4_idle", 32'({req_ready_4, busy_4}), 32'h2);
      while (!resp_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("to16_cycle", 32'(cyc), 32'd17);
      chk("to16_err", 32'({resp_valid, err, rdata == 32'h0}), 32'h7);
      tick();
      chk("to16_idle", 32'(req_ready), 32'h1);

      // gnt on the last allowed cycle beats the timeout
      issue(1'b1, 2'd2, 1'b0, 32'h700, 32'h5555_AAAA);
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("tie_dut4", 32'({resp_valid_4, err_4}), 32'h2);
      chk("tie_dut", 32'({resp_valid, err}), 32'h2);
      tick();

      // Reset during REQ drops mem_req_o immediately
      issue(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
      tick();
      req_valid = 1'b0;
      chk("rstreq_pre", 32'(mem_req), 32'h1);
      rst = 1'b1;
      #1;
      chk_reset_state("rstreq");
      tick();
      rst = 1'b0;
      tick();

      // Reset during WAIT, then a late rvalid must not produce a response
      issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
      tick();
      req_valid = 1'b0;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("rstwait_pre", 32'({busy, mem_req}), 32'h2);
      rst = 1'b1;
      #1;
      chk_reset_state("rstwait");
      tick();
      rst = 1'b0;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      for (int c = 0; c < 3; c++) begin
         chk_reset_state("rstwait_late");
         tick();
      end

`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 2'd2, 1'b0, 32'h006, 32'h0);
      tick();
      req_valid = 1'b0;
      chk("mis_resp", 32'({resp_valid, err, misalign, mem_req}), 32'hE);
      chk("mis_rdata", rdata, 32'h0);
      tick();
      chk("mis_idle", 32'({req_ready, mem_req, misalign}), 32'h4);
`else
      v = '{1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 32'hA1B2_C3D4, 0, 4'b1111, 32'h0, 32'hA1B2_C3D4};
      run_vec(v);
      v = '{1'b0, 2'd1, 1'b0, 32'h003, 32'h0, 32'h80FF_0000, 0, 4'b1100, 32'h0, 32'hFFFF_80FF};
      run_vec(v);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
